// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice (two half adders plus an OR) is
// sequenced LSB first over WIDTH-bit operands, with a start/busy/done handshake.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] ps;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_half;
  logic             c_half;
  logic             s_bit;
  logic             c_second;
  logic             carry_next;
  logic [WIDTH-1:0] ps_next;
  logic             accept;

  half_adder ha_ab (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .s (s_half),
    .c (c_half)
  );

  half_adder ha_cin (
    .x (s_half),
    .y (carry),
    .s (s_bit),
    .c (c_second)
  );

  assign carry_next = c_half | c_second;

  // New sum bit enters at the MSB so the LSB-first bits end up in place.
  always_comb begin
    ps_next            = ps >> 1;
    ps_next[WIDTH-1]   = s_bit;
  end

  assign accept = start && ((state == IDLE) || (state == DONE));

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= c_in;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          ps    <= ps_next;
          carry <= carry_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= ps_next;
            c_out <= carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a scoreboard queue holds expected
// {c_out, sum} per accepted start; a negedge monitor pops it on each done.

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             clk_en;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  int               n_checks;
  int               n_fail;
  int               done_cnt;
  int               busy_cnt;
  logic [WIDTH:0]   exp_q[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          check("result", 32'({c_out, sum}), 32'(e));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    a     = av;
    b     = bv;
    c_in  = cv;
    start = 1'b1;
    exp_q.push_back({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv});
  endtask

  task automatic wait_done(input int max_cycles, output int cycles);
    int base;
    base   = done_cnt;
    cycles = 0;
    while (done_cnt == base && cycles < max_cycles) begin
      step();
      cycles++;
    end
    if (done_cnt == base) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic single_add(input string tag, input logic [WIDTH-1:0] av,
                            input logic [WIDTH-1:0] bv, input logic cv);
    int cyc;
    busy_cnt = 0;
    drive(av, bv, cv);
    step();
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    wait_done(4 * WIDTH, cyc);
    check({tag, "_busy_len"}, 32'(busy_cnt), 32'(WIDTH));
    step();
    check({tag, "_done_fall"}, 32'(done), 32'(0));
  endtask

  initial begin
    int cyc;
    int base;
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    busy_cnt = 0;
    clk      = 1'b0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    c_in     = 1'b0;

    // Reset with the clock stopped must clear outputs without an edge.
    #3 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(c_out), 32'(0));
    clk_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    single_add("basic", 8'h5A, 8'h33, 1'b0);
    single_add("carry_ff01", 8'hFF, 8'h01, 1'b0);
    single_add("carry_ffff", 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      single_add("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    // Start while busy: the second request must be ignored entirely.
    busy_cnt = 0;
    base     = done_cnt;
    drive(8'h10, 8'h20, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) step();
    check("swb_done_count", 32'(done_cnt - base), 32'(1));
    check("swb_busy_len", 32'(busy_cnt), 32'(WIDTH));
    check("swb_sum", 32'(sum), 32'(8'h30));

    // Back-to-back: start held through DONE with new operands.
    drive(8'h01, 8'h01, 1'b0);
    wait_done(4 * WIDTH, cyc);
    drive(8'h7F, 8'h01, 1'b0);
    step();
    start = 1'b0;
    check("b2b_busy_again", 32'(busy), 32'(1));
    check("b2b_done_low", 32'(done), 32'(0));
    check("b2b_sum_hold", 32'(sum), 32'(8'h02));
    wait_done(4 * WIDTH, cyc);
    check("b2b_second_latency", 32'(cyc), 32'(WIDTH));
    check("b2b_final_sum", 32'(sum), 32'(8'h80));
    step();

    // Reset in the middle of RUN: outputs clear at once, no done for it.
    drive(8'h5A, 8'h33, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2 rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    check("mid_rst_sum", 32'(sum), 32'(0));
    check("mid_rst_cout", 32'(c_out), 32'(0));
    base = done_cnt;
    for (int i = 0; i < WIDTH; i++) step();
    rst = 1'b0;
    for (int i = 0; i < WIDTH; i++) step();
    check("mid_rst_no_done", 32'(done_cnt - base), 32'(0));
    single_add("after_rst", 8'h03, 8'h04, 1'b0);
    check("after_rst_sum", 32'(sum), 32'(8'h07));

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder controller that sequences a single one-bit full-adder slice over WIDTH-bit operands, LSB first. It trades area for latency: one bit per clock, WIDTH cycles per addition. The slice is built from two `half_adder` instances plus an OR for carry-out, and the block exposes a start/busy/done handshake to whatever logic issues additions.

## Interface

Parameters:
- `WIDTH`, default 8. Operand and sum width; legal range is WIDTH ≥ 1.

Ports (all outputs are registered). The design uses one clock; reset is asynchronous and active-high.
- `clk`  input  1  System clock; all state updates on the rising edge.
- `rst`  input  1  Asynchronous, active-high reset.
- `start`  input  1  Request a new addition; sampled on rising edges.
- `a`  input  WIDTH  Operand A; sampled only on the accepting edge.
- `b`  input  WIDTH  Operand B; sampled only on the accepting edge.
- `c_in`  input  1  Carry-in; sampled only on the accepting edge.
- `busy`  output  1  High while the addition is in progress (RUN state).
- `done`  output  1  One-cycle pulse: the result has just been updated.
- `sum`  output  WIDTH  Result of the last completed addition.
- `c_out`  output  1  Carry-out of the last completed addition.

## Operation

- States are IDLE, RUN and DONE. Reset places the block in IDLE.
- Reset values: `busy=0`, `done=0`, `sum=0`, `c_out=0`. Internal shift registers, carry flop and bit counter all clear to 0.
- **IDLE:**
  - `start=1` on an edge loads `a` and `b` into shift registers, loads `c_in` into the carry flop and clears the bit counter. Next state is RUN.
  - Otherwise the block stays in IDLE.
- **RUN:** on each edge:
  - Slice inputs are `a_sh[0]`, `b_sh[0]` and `carry`.
  - `s = a_sh[0]^b_sh[0]^carry`; `carry <= majority(a_sh[0], b_sh[0], carry)`.
  - `s` shifts into the MSB of the partial-sum register; `a_sh` and `b_sh` shift right by one.
  - The counter increments.
  - On the edge that processes bit WIDTH-1, `sum` gets the complete partial sum (including that bit), `c_out` gets the final carry, and next state is DONE.
- **DONE:**
  - `done=1` for exactly one cycle.
  - If `start=1` on the edge leaving DONE, a new addition is accepted exactly as from IDLE and next state is RUN.
  - Otherwise next state is IDLE.
- `start` is ignored in RUN. Operands are not re-sampled, and there is no queueing.
- `sum` and `c_out` change only on the completion edge. They hold the previous result throughout a new RUN.
- Arithmetic is unsigned. `{c_out, sum}` equals `a + b + c_in` for the full (WIDTH+1)-bit result, with no overflow flag.
- WIDTH=1: RUN lasts one cycle and the flow is otherwise identical.
- Reset asserted mid-operation:
  - The state returns to IDLE immediately and `busy`, `done`, `sum` and `c_out` clear asynchronously.
  - No `done` pulse is produced for the aborted operation.

## Timing

- The accepting edge is E0; `busy` rises after E0.
- Bits 0..WIDTH-1 are processed on edges E1..E(WIDTH).
- `sum`/`c_out` update and `done` rises after E(WIDTH). `busy` falls on that same edge.
- `done` falls after E(WIDTH+1).
- Latency from the accepting edge to `done` high is WIDTH cycles. Peak throughput is one addition per WIDTH+1 cycles, with `start` held through DONE.
- `a`, `b` and `c_in` may change freely after E0.
- There are no combinational paths from inputs to outputs.
- Reset assertion takes effect without a clock edge. On release, the first edge with `start=1` is accepted.

## Test plan

- **Reset:** assert `rst` mid-cycle with the clock stopped → `busy=0`, `done=0`, `sum=0x00`, `c_out=0` immediately.
- **Basic add:** WIDTH=8, `a=0x5A`, `b=0x33`, `c_in=0`, `start` pulsed one cycle → `busy` high for 8 cycles, then `done` pulses for one cycle with `sum=0x8D`, `c_out=0`.
- **Carry chain:**
  - `a=0xFF`, `b=0x01`, `c_in=0` → `sum=0x00`, `c_out=1`.
  - `a=0xFF`, `b=0xFF`, `c_in=1` → `sum=0xFF`, `c_out=1`.
- **Start while busy:** start `0x10+0x20`, then on cycle 3 of RUN pulse `start` with `a=0xAA`, `b=0x55` → exactly one `done`, `sum=0x30`; `busy` does not re-extend.
- **Back-to-back:** hold `start=1` with `0x01+0x01`, then switch the operands to `0x7F+0x01` during DONE → first `done` shows `sum=0x02`, `busy` re-asserts immediately, `sum` holds `0x02` during RUN, and the second `done` arrives 8 cycles later with `sum=0x80`.
- **Reset mid-RUN:** assert `rst` on RUN cycle 4 of `0x5A+0x33` → outputs clear, no `done`; after release, `0x03+0x04` completes normally with `sum=0x07`.
